sipo_align_ctrl: RTL and testbench

- Word-alignment and framing controller for the 10-bit serial deserialiser path.
- Keeps its own 10-bit shift window of the incoming serial stream and hunts for the K28.5 comma.
- Confirms alignment over several consecutive commas, then delivers aligned 10-bit words through a valid/ready handshake.
- Detects loss of alignment and re-hunts. Sits between the line receiver and the 8b/10b decoder.

---
 rtl/sipo_align_pkg.sv | 17 +
 rtl/sipo_align_outreg.sv | 51 +++++
 rtl/sipo_align_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sipo_align_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_align_pkg.sv
// Shared types and constants for the serial word-alignment controller.
package sipo_align_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CONFIRM,
    LOCKED
  } align_state_t;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  function automatic logic is_comma(input logic [9:0] w);
    return (w == K28_5_RDN) || (w == K28_5_RDP);
  endfunction

endpackage

// File: rtl/sipo_align_outreg.sv
// Holding register for aligned words: valid/ready handshake and sticky overflow.
// Optional macro SIPO_ALIGN_COMMA_DROP_EN ties word_is_comma low.
module sipo_align_outreg (
  input  logic       clk,
  input  logic       reset,
  input  logic       capture,
  input  logic [9:0] cap_word,
  input  logic       word_ready,
  input  logic       clr_ovf,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       word_is_comma,
  output logic       ovf
);
  import sipo_align_pkg::*;

  logic drop;

  assign drop = capture && word_valid && !word_ready;

`ifdef SIPO_ALIGN_COMMA_DROP_EN
  assign word_is_comma = 1'b0;
`else
  assign word_is_comma = is_comma(word_out);
`endif

  // Load a new word when the slot is free or being emptied; otherwise release on acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (capture && !drop) begin
      word_out   <= cap_word;
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; a drop on the same edge as a clear keeps it set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_align_ctrl.sv
// K28.5 comma hunter and word-alignment FSM for the 10-bit deserialiser path.
// Optional macro SIPO_ALIGN_COMMA_DROP_EN: comma words are not delivered in LOCKED.
module sipo_align_ctrl #(
  parameter int CONFIRM_CNT = 3,
  parameter int LOSS_CNT    = 4,
  parameter int CONFIRM_TMO = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       din,
  input  logic       din_valid,
  output logic [9:0] word_out,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       word_is_comma,
  output logic       locked,
  output logic       lock_lost,
  output logic       ovf,
  input  logic       clr_ovf
);
  import sipo_align_pkg::*;

  localparam int TMO_W = $clog2(CONFIRM_TMO + 1);
  localparam logic [3:0]       CONF_TGT = 4'(CONFIRM_CNT);
  localparam logic [3:0]       LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [TMO_W-1:0] TMO_TGT  = TMO_W'(CONFIRM_TMO);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  align_state_t     state;
  logic [9:0]       win;
  logic [9:0]       win_next;
  logic [3:0]       bit_cnt;
  logic [3:0]       conf_cnt;
  logic [3:0]       miss_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             comma_hit;
  logic             boundary;
  logic             capture;

  // Next window contents, comma/boundary detection and capture decision for this edge
  always_comb begin
    win_next  = {din, win[9:1]};
    comma_hit = din_valid && is_comma(win_next);
    boundary  = din_valid && (bit_cnt == 4'd9);
    capture   = en && boundary && (state == LOCKED);
`ifdef SIPO_ALIGN_COMMA_DROP_EN
    capture   = capture && !comma_hit;
`endif
  end

  // Serial shift window, oldest bit ends up in bit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win <= '0;
    end else if (din_valid) begin
      win <= win_next;
    end
  end

  // Alignment FSM with its counters and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      conf_cnt  <= '0;
      miss_cnt  <= '0;
      tmo_cnt   <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (!en) begin
        state    <= HUNT;
        bit_cnt  <= '0;
        conf_cnt <= '0;
        miss_cnt <= '0;
        tmo_cnt  <= '0;
        locked   <= 1'b0;
        if (state == LOCKED) begin
          lock_lost <= 1'b1;
        end
      end else if (din_valid) begin
        bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
        case (state)
          HUNT: begin
            if (comma_hit) begin
              bit_cnt  <= '0;
              tmo_cnt  <= '0;
              miss_cnt <= '0;
              conf_cnt <= 4'd1;
              if (CONFIRM_CNT == 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (comma_hit && boundary) begin
              tmo_cnt  <= '0;
              conf_cnt <= conf_cnt + 4'd1;
              if (conf_cnt + 4'd1 == CONF_TGT) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (comma_hit) begin
              state    <= HUNT;
              conf_cnt <= '0;
              tmo_cnt  <= '0;
            end else if (boundary) begin
              if (tmo_cnt + TMO_ONE == TMO_TGT) begin
                state    <= HUNT;
                conf_cnt <= '0;
                tmo_cnt  <= '0;
              end else begin
                tmo_cnt <= tmo_cnt + TMO_ONE;
              end
            end
          end
          LOCKED: begin
            if (comma_hit && boundary) begin
              miss_cnt <= '0;
            end else if (comma_hit) begin
              if (miss_cnt + 4'd1 == LOSS_TGT) begin
                state     <= HUNT;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                miss_cnt  <= '0;
                conf_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sipo_align_outreg u_outreg (
    .clk           (clk),
    .reset         (reset),
    .capture       (capture),
    .cap_word      (win_next),
    .word_ready    (word_ready),
    .clr_ovf       (clr_ovf),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_is_comma (word_is_comma),
    .ovf           (ovf)
  );

endmodule

// File: tb/tb_sipo_align_ctrl.sv
// Directed bench for sipo_align_ctrl: hunt, confirm, lock, loss, overflow, reset, comma drop.
module tb_sipo_align_ctrl;
  import sipo_align_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       word_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [9:0] word_out;
  logic       word_valid;
  logic       word_is_comma;
  logic       locked;
  logic       lock_lost;
  logic       ovf;

  int nChecks = 0;
  int nFail   = 0;

`ifdef SIPO_ALIGN_COMMA_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  sipo_align_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .din           (din),
    .din_valid     (din_valid),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .word_is_comma (word_is_comma),
    .locked        (locked),
    .lock_lost     (lock_lost),
    .ovf           (ovf),
    .clr_ovf       (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic b, input logic v);
    din       = b;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [9:0] w);
    for (int i = 0; i < 10; i++) applyStimulus(w[i], 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [9:0] tbWin;
    logic [9:0] nxt;
    logic       b;
    logic       seenValid;
    logic       seenLocked;
    logic [9:0] d155;

    d155 = 10'h155;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    en    = 1'b1;
    checkOutput("rst_word_out", word_out, 10'h000);
    checkOutput("rst_word_valid", word_valid, 10'd0);
    checkOutput("rst_is_comma", word_is_comma, 10'd0);
    checkOutput("rst_locked", locked, 10'd0);
    checkOutput("rst_lock_lost", lock_lost, 10'd0);
    checkOutput("rst_ovf", ovf, 10'd0);

    // 200 random bits that never form a comma
    $display("[TB] idle random stream");
    word_ready = 1'b1;
    tbWin      = '0;
    seenValid  = 1'b0;
    seenLocked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      b   = 1'($urandom_range(0, 1));
      nxt = {b, tbWin[9:1]};
      if (is_comma(nxt)) begin
        b   = ~b;
        nxt = {b, tbWin[9:1]};
      end
      tbWin = nxt;
      applyStimulus(b, 1'b1);
      if (word_valid) seenValid = 1'b1;
      if (locked) seenLocked = 1'b1;
    end
    checkOutput("idle_valid_seen", seenValid, 10'd0);
    checkOutput("idle_locked_seen", seenLocked, 10'd0);

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    reset = 1'b1;

    // three aligned commas then data
    $display("[TB] lock and deliver");
    sendWord(K28_5_RDN);
    sendWord(K28_5_RDN);
    checkOutput("lock_after2", locked, 10'd0);
    sendWord(K28_5_RDN);
    checkOutput("lock_after3", locked, 10'd1);
    checkOutput("lock_no_word", word_valid, 10'd0);
    for (int i = 0; i < 9; i++) applyStimulus(d155[i], 1'b1);
    checkOutput("w155_9bits_valid", word_valid, 10'd0);
    applyStimulus(d155[9], 1'b1);
    checkOutput("w155_valid", word_valid, 10'd1);
    checkOutput("w155_data", word_out, 10'h155);
    checkOutput("w155_is_comma", word_is_comma, 10'd0);
    sendWord(10'h2AA);
    checkOutput("w2AA_valid", word_valid, 10'd1);
    checkOutput("w2AA_data", word_out, 10'h2AA);
    applyStimulus(1'b0, 1'b0);
    checkOutput("w2AA_accepted", word_valid, 10'd0);

    // four commas shifted by 3 bits break the lock
    $display("[TB] loss of alignment");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    sendWord(K28_5_RDN);
    sendWord(K28_5_RDN);
    sendWord(K28_5_RDN);
    checkOutput("miss3_locked", locked, 10'd1);
    checkOutput("miss3_lost", lock_lost, 10'd0);
    sendWord(K28_5_RDN);
    checkOutput("miss4_lost", lock_lost, 10'd1);
    checkOutput("miss4_locked", locked, 10'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("lost_pulse_end", lock_lost, 10'd0);
    sendWord(K28_5_RDN);
    sendWord(K28_5_RDN);
    checkOutput("relock_after2", locked, 10'd0);
    sendWord(K28_5_RDN);
    checkOutput("relock_after3", locked, 10'd1);

    // consumer stalls for 25 bit times
    $display("[TB] overflow and drain");
    word_ready = 1'b0;
    sendWord(10'h155);
    checkOutput("stall_first_valid", word_valid, 10'd1);
    checkOutput("stall_first_ovf", ovf, 10'd0);
    sendWord(10'h2AA);
    for (int i = 0; i < 5; i++) applyStimulus(d155[i], 1'b1);
    checkOutput("stall_ovf", ovf, 10'd1);
    checkOutput("stall_held", word_out, 10'h155);
    checkOutput("stall_valid", word_valid, 10'd1);
    clr_ovf = 1'b1;
    applyStimulus(1'b0, 1'b0);
    clr_ovf = 1'b0;
    checkOutput("clr_ovf", ovf, 10'd0);
    for (int i = 5; i < 9; i++) applyStimulus(d155[i], 1'b1);
    clr_ovf = 1'b1;
    applyStimulus(d155[9], 1'b1);
    clr_ovf = 1'b0;
    checkOutput("ovf_wins_clr", ovf, 10'd1);
    checkOutput("still_held", word_out, 10'h155);
    word_ready = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("drain_valid", word_valid, 10'd0);

    // enable drop while a word is pending
    $display("[TB] enable low and async reset");
    word_ready = 1'b0;
    sendWord(10'h155);
    sendWord(10'h2AA);
    en = 1'b0;
    applyStimulus(1'b0, 1'b0);
    en = 1'b1;
    checkOutput("en_lost", lock_lost, 10'd1);
    checkOutput("en_locked", locked, 10'd0);
    checkOutput("en_pending", word_valid, 10'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("en_lost_end", lock_lost, 10'd0);
    word_ready = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("en_drained", word_valid, 10'd0);
    sendWord(K28_5_RDN);
    for (int i = 0; i < 4; i++) applyStimulus(d155[i], 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_word_out", word_out, 10'h000);
    checkOutput("arst_ovf", ovf, 10'd0);
    checkOutput("arst_valid", word_valid, 10'd0);
    checkOutput("arst_locked", locked, 10'd0);
    checkOutput("arst_lost", lock_lost, 10'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sendWord(K28_5_RDN);
    sendWord(K28_5_RDN);
    sendWord(K28_5_RDN);
    checkOutput("arst_relock", locked, 10'd1);

    // comma words inside a locked stream
    $display("[TB] comma delivery");
    sendWord(K28_5_RDN);
    checkOutput("cw1_valid", word_valid, DROP ? 10'd0 : 10'd1);
    checkOutput("cw1_is_comma", word_is_comma, DROP ? 10'd0 : 10'd1);
    sendWord(10'h0F0);
    checkOutput("cw2_valid", word_valid, 10'd1);
    checkOutput("cw2_data", word_out, 10'h0F0);
    checkOutput("cw2_is_comma", word_is_comma, 10'd0);
    sendWord(K28_5_RDN);
    checkOutput("cw3_valid", word_valid, DROP ? 10'd0 : 10'd1);
    checkOutput("cw3_data", word_out, DROP ? 10'h0F0 : 10'h17C);
    checkOutput("cw3_ovf", ovf, 10'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
